// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word type and memory-stage FSM states.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} memstate_t;
endpackage

// File: rtl/llsc_link.sv
// llsc_link: load-linked reservation register with remote-snoop and local-store invalidation.
module llsc_link (
   input  logic        clk,
   input  logic        rst,
   input  logic        set,
   input  logic [29:0] set_addr,
   input  logic        wr_done,
   input  logic [29:0] wr_addr,
   input  logic        snoop_valid,
   input  logic [29:0] snoop_addr,
   output logic        link_valid,
   output logic [29:0] link_addr
);
   // A snoop to the address being linked in the same cycle cancels the new link.
   always_ff @(posedge clk)
      if (rst) begin
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else if (set) begin
         link_valid <= !(snoop_valid && snoop_addr == set_addr);
         link_addr  <= set_addr;
      end else if ((snoop_valid && snoop_addr == link_addr) || (wr_done && wr_addr == link_addr))
         link_valid <= 1'b0;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a stalling data cache; LL/SC support when LLSC_EN is defined.
module mem_stage
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        reqValid,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic        isLL,
   input  logic        isSC,
   input  logic [31:0] addr,
   input  logic [31:0] storeData,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic        dhit,
   input  logic [31:0] dload,
   input  logic        snoopValid,
   input  logic [31:0] snoopAddr,
   output logic [31:0] dmemload,
   output logic [31:0] scStatus,
   output logic        memStall,
   output logic        memDone
);
   memstate_t state;
   logic op_rd, op_wr, op_ll, op_sc;
   logic accept, sc_fail, unused_bits;
   assign accept   = reqValid && (memRead || memWrite);
   assign memStall = !RST && (state == ACCESS || (state == IDLE && accept));
`ifdef LLSC_EN
   logic        link_valid;
   logic [29:0] link_addr;
   llsc_link u_link (
      .clk         (CLK),
      .rst         (RST),
      .set         (state == ACCESS && dhit && op_ll),
      .set_addr    (daddr[31:2]),
      .wr_done     (state == ACCESS && dhit && op_wr),
      .wr_addr     (daddr[31:2]),
      .snoop_valid (snoopValid),
      .snoop_addr  (snoopAddr[31:2]),
      .link_valid  (link_valid),
      .link_addr   (link_addr)
   );
   // An SC without a live reservation on its word completes at once as a failure.
   assign sc_fail     = isSC && !memRead && !(link_valid && link_addr == addr[31:2]);
   assign unused_bits = ^{addr[1:0], snoopAddr[1:0]};
`else
   assign sc_fail     = 1'b0;
   assign unused_bits = ^{addr[1:0], snoopAddr, snoopValid, isLL, op_ll};
`endif
   always_ff @(posedge CLK)
      if (RST) begin
         state    <= IDLE;
         op_rd    <= 1'b0;
         op_wr    <= 1'b0;
         op_ll    <= 1'b0;
         op_sc    <= 1'b0;
         dREN     <= 1'b0;
         dWEN     <= 1'b0;
         daddr    <= '0;
         dstore   <= '0;
         dmemload <= '0;
         scStatus <= '0;
         memDone  <= 1'b0;
      end else begin
         memDone <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               op_rd  <= memRead;
               op_wr  <= !memRead;
               op_ll  <= isLL && memRead;
               op_sc  <= isSC && !memRead;
               daddr  <= {addr[31:2], 2'b00};
               dstore <= storeData;
               if (sc_fail) begin
                  state    <= DONE;
                  scStatus <= 32'd0;
                  memDone  <= 1'b1;
               end else begin
                  state <= ACCESS;
                  dREN  <= memRead;
                  dWEN  <= !memRead;
               end
            end
            ACCESS: if (dhit) begin
               state   <= DONE;
               dREN    <= 1'b0;
               dWEN    <= 1'b0;
               memDone <= 1'b1;
               if (op_rd) dmemload <= dload;
               if (op_sc) scStatus <= 32'd1;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: CLK  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: RST  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: reqValid in 1 (EX/MEM entry valid); memRead in 1; memWrite in 1; isLL in 1; isSC in 1; addr in 32 (word_t); storeData in 32.
REQ-004 SHALL have ports: dREN out 1; dWEN out 1; daddr out 32; dstore out 32; dhit in 1 (data cache access complete); dload in 32.
REQ-005 SHALL have ports: snoopValid in 1 (remote write observed); snoopAddr in 32.
REQ-006 SHALL have outputs:
- dmemload out 32: registered load data for MEM/WB.
- scStatus out 32: 1 = SC success, 0 = SC failure.
- memStall out 1: freezes EX/MEM and holds MEM/WB EN low.
- memDone out 1: one-cycle completion pulse.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS and DONE; the state SHALL be IDLE after reset.
REQ-008 IDLE: when reqValid and (memRead or memWrite), SHALL capture op, {addr[31:2],2'b00} and storeData, then go to ACCESS; otherwise SHALL stay in IDLE.
REQ-009 memStall SHALL equal (IDLE and an accepted request) or ACCESS; it SHALL be 0 in DONE.
REQ-010 ACCESS: SHALL drive dREN = captured read, dWEN = captured write, daddr and dstore from the captured values, and hold them until dhit.
REQ-011 On dhit in ACCESS: SHALL register dload into dmemload (reads only) and go to DONE; dREN/dWEN SHALL be 0 from the next cycle.
REQ-012 DONE: SHALL pulse memDone for exactly one cycle and return to IDLE; minimum latency from accept to memDone is 2 cycles.
REQ-013 dREN and dWEN SHALL never both be 1 and SHALL be 0 outside ACCESS; if memRead and memWrite are both set, read SHALL take priority.
REQ-014 dmemload and scStatus SHALL hold their values until the next completion.
REQ-015 LL SHALL perform a read; on its dhit, SHALL set linkValid=1 and linkAddr to the captured address.
REQ-016 SC in IDLE with linkValid=0 or linkAddr!=addr[31:2]: SHALL go directly to DONE with scStatus=0, never asserting dWEN.
REQ-017 SC with a matching link: SHALL write; on dhit, scStatus=1 and linkValid cleared.
REQ-018 SHALL clear linkValid on:
- snoopValid with snoopAddr[31:2]==linkAddr;
- local SW completing to linkAddr.
REQ-019 Snoop matching the LL address in the same cycle as LL dhit: snoop SHALL win and linkValid SHALL remain 0.
REQ-020 A non-LL/SC access SHALL leave scStatus unchanged.

Reset
REQ-021 On RST=1 at an edge: SHALL set state=IDLE and clear dREN, dWEN, daddr, dstore, dmemload, scStatus, memDone, linkValid and linkAddr.
REQ-022 RST asserted mid-ACCESS SHALL abandon the access with no memDone, and dREN/dWEN SHALL be 0 in the following cycle.
REQ-023 While RST=1, memStall SHALL be 0.

Configuration
REQ-024 Macro LLSC_EN defined: REQ-015..REQ-019 SHALL apply.
REQ-025 LLSC_EN undefined: LL SHALL behave as a plain read, SC as a plain write with scStatus=1, and no link state SHALL be instantiated.

Structure
REQ-026 word_t and memstate_t (IDLE/ACCESS/DONE) SHALL live in cpu_types_pkg.
REQ-027 Link register and snoop compare SHALL be sub-module llsc_link, instantiated only under LLSC_EN.

Verification
REQ-028 LW to 0x0000_0040 with dhit after 3 wait cycles, dload=0xDEADBEEF -> dREN for 4 cycles, daddr=0x40, dmemload=0xDEADBEEF, one memDone pulse.
REQ-029 SW 0x12345678 to 0x0000_0083 with dhit immediate -> daddr=0x80, dstore=0x12345678, dWEN for 1 cycle, memDone 2 cycles after accept.
REQ-030 LL 0x100 then SC 0x100 -> SC writes, scStatus=1; a second SC 0x100 -> no dWEN, scStatus=0.
REQ-031 LL 0x100, snoop 0x102, SC 0x100 -> scStatus=0, dWEN never asserted; snoop coincident with LL dhit -> link not set.
REQ-032 RST pulsed during ACCESS (dhit never given) -> next cycle dREN=0, state IDLE, no memDone, dmemload=0.
REQ-033 With LLSC_EN undefined, SC 0x200 without a prior LL -> dWEN asserted, scStatus=1.
